gs_pingpong_ctrl: RTL and testbench

GS_PINGPONG_CTRL -- requirements
Module: gs_pingpong_ctrl

---
 rtl/gs_pingpong_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_gs_pingpong_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gs_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gs_pingpong_ctrl
//  Description : Ping-pong line-buffer read controller. Picks a ready bank,
//                streams one line of read addresses, collects filter results
//                into the output buffer, then releases the bank. Drain phase
//                is guarded by a timeout that sets a sticky error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module gs_pingpong_ctrl #(
    parameter int LINE_LEN  = 256,
    parameter int ADDR_W    = 8,
    parameter int DRAIN_MAX = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ctrl_en,
    input  logic [1:0]        i_bank_ready,
    input  logic              i_op_valid_out,
    output logic              o_ram0_rd_en,
    output logic              o_ram1_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_filt_start,
    output logic              o_out_wr_en,
    output logic [ADDR_W-1:0] o_out_wr_addr,
    output logic [1:0]        o_bank_release,
    output logic              o_line_done,
    output logic              o_busy,
    output logic              o_err
);

    localparam int                 DRAIN_W      = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX + 1) : 1;
    localparam logic [ADDR_W-1:0]  c_LAST_ADDR  = ADDR_W'(LINE_LEN - 1);
    localparam logic [ADDR_W:0]    c_LINE_LEN   = (ADDR_W + 1)'(LINE_LEN);
    localparam logic [DRAIN_W-1:0] c_DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Control state
    state_t             r_state;
    logic               r_cur_bank;
    logic               r_last_served;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [ADDR_W:0]    r_wr_cnt;       // one extra bit so LINE_LEN = 2^ADDR_W is reachable
    logic [DRAIN_W-1:0] r_drain_cnt;

    // Registered outputs
    logic               r_ram0_rd_en;
    logic               r_ram1_rd_en;
    logic               r_filt_start;
    logic               r_out_wr_en;
    logic [ADDR_W-1:0]  r_out_wr_addr;
    logic [1:0]         r_bank_release;
    logic               r_line_done;
    logic               r_busy;
    logic               r_err;

    // Next-state values
    state_t             w_state_nxt;
    logic               w_cur_bank_nxt;
    logic               w_last_served_nxt;
    logic [ADDR_W-1:0]  w_rd_addr_nxt;
    logic [ADDR_W:0]    w_wr_cnt_nxt;
    logic [DRAIN_W-1:0] w_drain_cnt_nxt;
    logic               w_ram0_rd_en_nxt;
    logic               w_ram1_rd_en_nxt;
    logic               w_filt_start_nxt;
    logic               w_out_wr_en_nxt;
    logic [ADDR_W-1:0]  w_out_wr_addr_nxt;
    logic [1:0]         w_bank_release_nxt;
    logic               w_line_done_nxt;
    logic               w_busy_nxt;
    logic               w_err_nxt;

    logic               w_accept;
    logic [ADDR_W:0]    w_wr_cnt_inc;
    logic               w_sel_bank;

    // Next-state, counter and output decode; outputs follow the next state so
    // that every output is a flop aligned with the state it belongs to
    always_comb begin
        w_state_nxt        = r_state;
        w_cur_bank_nxt     = r_cur_bank;
        w_last_served_nxt  = r_last_served;
        w_rd_addr_nxt      = r_rd_addr;
        w_wr_cnt_nxt       = r_wr_cnt;
        w_drain_cnt_nxt    = r_drain_cnt;
        w_err_nxt          = r_err;

        // Filter results only count while a line is in flight
        w_accept     = i_op_valid_out && ((r_state == S_READ) || (r_state == S_DRAIN));
        w_wr_cnt_inc = r_wr_cnt + {{ADDR_W{1'b0}}, w_accept};

        // Both ready: alternate away from the last served bank
        w_sel_bank = (i_bank_ready == 2'b11) ? ~r_last_served : i_bank_ready[1];

        case (r_state)
            S_IDLE: begin
                if (i_ctrl_en && (i_bank_ready != 2'b00)) begin
                    w_state_nxt    = S_START;
                    w_cur_bank_nxt = w_sel_bank;
                end
            end
            S_START: begin
                w_rd_addr_nxt   = '0;
                w_wr_cnt_nxt    = '0;
                w_drain_cnt_nxt = '0;
                w_state_nxt     = S_READ;
            end
            S_READ: begin
                w_wr_cnt_nxt = w_wr_cnt_inc;
                if (r_rd_addr == c_LAST_ADDR) begin
                    w_rd_addr_nxt = '0;
                    w_state_nxt   = S_DRAIN;
                end else begin
                    w_rd_addr_nxt = r_rd_addr + 1'b1;
                end
            end
            S_DRAIN: begin
                w_wr_cnt_nxt = w_wr_cnt_inc;
                if (w_wr_cnt_inc >= c_LINE_LEN) begin
                    w_state_nxt = S_DONE;
                end else if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_last_served_nxt = r_cur_bank;
                w_state_nxt       = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_ram0_rd_en_nxt   = (w_state_nxt == S_READ) && !w_cur_bank_nxt;
        w_ram1_rd_en_nxt   = (w_state_nxt == S_READ) &&  w_cur_bank_nxt;
        w_filt_start_nxt   = (w_state_nxt == S_START);
        w_out_wr_en_nxt    = w_accept;
        w_line_done_nxt    = (w_state_nxt == S_DONE);
        w_busy_nxt         = (w_state_nxt != S_IDLE);
        w_bank_release_nxt = 2'b00;
        if (w_state_nxt == S_DONE) begin
            w_bank_release_nxt = w_cur_bank_nxt ? 2'b10 : 2'b01;
        end

        // Write address is presented alongside its strobe and held in between
        w_out_wr_addr_nxt = r_out_wr_addr;
        if (w_state_nxt == S_START) begin
            w_out_wr_addr_nxt = '0;
        end else if (w_accept) begin
            w_out_wr_addr_nxt = r_wr_cnt[ADDR_W-1:0];
        end
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cur_bank     <= 1'b0;
            r_last_served  <= 1'b1;
            r_rd_addr      <= '0;
            r_wr_cnt       <= '0;
            r_drain_cnt    <= '0;
            r_ram0_rd_en   <= 1'b0;
            r_ram1_rd_en   <= 1'b0;
            r_filt_start   <= 1'b0;
            r_out_wr_en    <= 1'b0;
            r_out_wr_addr  <= '0;
            r_bank_release <= 2'b00;
            r_line_done    <= 1'b0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cur_bank     <= w_cur_bank_nxt;
            r_last_served  <= w_last_served_nxt;
            r_rd_addr      <= w_rd_addr_nxt;
            r_wr_cnt       <= w_wr_cnt_nxt;
            r_drain_cnt    <= w_drain_cnt_nxt;
            r_ram0_rd_en   <= w_ram0_rd_en_nxt;
            r_ram1_rd_en   <= w_ram1_rd_en_nxt;
            r_filt_start   <= w_filt_start_nxt;
            r_out_wr_en    <= w_out_wr_en_nxt;
            r_out_wr_addr  <= w_out_wr_addr_nxt;
            r_bank_release <= w_bank_release_nxt;
            r_line_done    <= w_line_done_nxt;
            r_busy         <= w_busy_nxt;
            r_err          <= w_err_nxt;
        end
    end

    assign o_ram0_rd_en   = r_ram0_rd_en;
    assign o_ram1_rd_en   = r_ram1_rd_en;
    assign o_rd_addr      = r_rd_addr;
    assign o_filt_start   = r_filt_start;
    assign o_out_wr_en    = r_out_wr_en;
    assign o_out_wr_addr  = r_out_wr_addr;
    assign o_bank_release = r_bank_release;
    assign o_line_done    = r_line_done;
    assign o_busy         = r_busy;
    assign o_err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gs_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gs_pingpong_ctrl
//  Description : Directed bench for gs_pingpong_ctrl; a 10-cycle downstream
//                delay model feeds op_valid_out back from the read strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gs_pingpong_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ctrl_en, ctrl_en2;
    logic [1:0] bank_ready, bank_ready2;
    logic       op_valid, op_valid2;
    logic       kill;

    logic       rd0, rd1, filt, wr_en, ldone, busy, err;
    logic [7:0] rd_addr, wr_addr;
    logic [1:0] rel;
    logic       rd0_2, rd1_2, filt2, wr_en2, ldone2, busy2, err2;
    logic [7:0] rd_addr2, wr_addr2;
    logic [1:0] rel2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gs_pingpong_ctrl u_dut (
        .clk(clk), .rst(rst), .i_ctrl_en(ctrl_en), .i_bank_ready(bank_ready),
        .i_op_valid_out(op_valid), .o_ram0_rd_en(rd0), .o_ram1_rd_en(rd1),
        .o_rd_addr(rd_addr), .o_filt_start(filt), .o_out_wr_en(wr_en),
        .o_out_wr_addr(wr_addr), .o_bank_release(rel), .o_line_done(ldone),
        .o_busy(busy), .o_err(err)
    );

    gs_pingpong_ctrl #(.LINE_LEN(2), .ADDR_W(8), .DRAIN_MAX(32)) u_dut2 (
        .clk(clk), .rst(rst), .i_ctrl_en(ctrl_en2), .i_bank_ready(bank_ready2),
        .i_op_valid_out(op_valid2), .o_ram0_rd_en(rd0_2), .o_ram1_rd_en(rd1_2),
        .o_rd_addr(rd_addr2), .o_filt_start(filt2), .o_out_wr_en(wr_en2),
        .o_out_wr_addr(wr_addr2), .o_bank_release(rel2), .o_line_done(ldone2),
        .o_busy(busy2), .o_err(err2)
    );

    // Downstream model: RAM + filter give valid 10 cycles after each read
    logic [9:0] sr, sr2;
    always @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            sr2 <= '0;
        end else begin
            sr  <= {sr[8:0],  rd0 | rd1};
            sr2 <= {sr2[8:0], rd0_2 | rd1_2};
        end
    end
    assign op_valid  = sr[9] & ~kill;
    assign op_valid2 = sr2[9];

    // Activity monitor: counts strobes and checks address sequencing
    int n_rd0 = 0, n_rd1 = 0, n_ovl = 0, n_rd_bad = 0, n_wr = 0, n_wr_bad = 0;
    int n_filt = 0, n_rel0 = 0, n_rel1 = 0, n_done = 0;
    int exp_rd = 0, exp_wr = 0;
    int served[$];
    int n2_rd = 0, n2_rd_bad = 0, n2_wr = 0, n2_wr_bad = 0, exp2_rd = 0, exp2_wr = 0;
    always @(negedge clk) begin
        if (filt) begin n_filt++; exp_rd = 0; exp_wr = 0; end
        if (rd0 && rd1) n_ovl++;
        if (rd0 || rd1) begin
            if (int'(rd_addr) != exp_rd) n_rd_bad++;
            if (rd_addr == 8'd0) served.push_back(rd1 ? 1 : 0);
            exp_rd++;
        end
        if (rd0) n_rd0++;
        if (rd1) n_rd1++;
        if (wr_en) begin
            if (int'(wr_addr) != exp_wr) n_wr_bad++;
            exp_wr++;
            n_wr++;
        end
        if (rel[0]) n_rel0++;
        if (rel[1]) n_rel1++;
        if (ldone) n_done++;
        if (filt2) begin exp2_rd = 0; exp2_wr = 0; end
        if (rd0_2 || rd1_2) begin
            if (int'(rd_addr2) != exp2_rd) n2_rd_bad++;
            exp2_rd++;
            n2_rd++;
        end
        if (wr_en2) begin
            if (int'(wr_addr2) != exp2_wr) n2_wr_bad++;
            exp2_wr++;
            n2_wr++;
        end
    end

    int b_rd0, b_rd1, b_ovl, b_wr, b_filt, b_rel0, b_rel1, b_done;

    task automatic snap();
        b_rd0 = n_rd0; b_rd1 = n_rd1; b_ovl = n_ovl; b_wr = n_wr;
        b_filt = n_filt; b_rel0 = n_rel0; b_rel1 = n_rel1; b_done = n_done;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Bounded wait: 0 filt, 1 line_done, 2 rd_addr==val, 3 filt2, 4 line_done2
    task automatic wait_for(input string tag, input int which, input int val,
                            input int max, output int n);
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n <= max) begin
            case (which)
                0: hit = filt;
                1: hit = ldone;
                2: hit = (rd0 || rd1) && (int'(rd_addr) == val);
                3: hit = filt2;
                default: hit = ldone2;
            endcase
            if (!hit) begin tick(); n++; end
        end
        if (!hit) begin
            total++;
            bad++;
            $error("FAIL %s observed=timeout expected=event within %0d cycles", tag, max);
            n = -1;
        end
    endtask

    task automatic run_line(input string tag, output int lat);
        int n;
        wait_for({tag, "_start"}, 0, 0, 50, n);
        wait_for({tag, "_done"}, 1, 0, 400, lat);
    endtask

    initial begin
        int lat, n, s0;

        // Reset state
        rst = 1'b1; ctrl_en = 1'b0; bank_ready = 2'b00; kill = 1'b0;
        ctrl_en2 = 1'b0; bank_ready2 = 2'b00;
        repeat (3) tick();
        chk("rst_rd0", rd0, 0);        chk("rst_rd1", rd1, 0);
        chk("rst_addr", rd_addr, 0);   chk("rst_filt", filt, 0);
        chk("rst_wr_en", wr_en, 0);    chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rel", rel, 0);        chk("rst_done", ldone, 0);
        chk("rst_busy", busy, 0);      chk("rst_err", err, 0);

        // Single line from bank 0
        snap();
        rst = 1'b0; bank_ready = 2'b01; ctrl_en = 1'b1;
        run_line("l1", lat);
        chk("l1_latency", lat, 267);
        chk("l1_rel", rel, 1);
        chk("l1_err", err, 0);
        bank_ready = 2'b00;
        tick();
        chk("l1_idle_busy", busy, 0);
        chk("l1_idle_rel", rel, 0);
        chk("l1_idle_done", ldone, 0);
        tick();
        chk("l1_rd0_cnt", n_rd0 - b_rd0, 256);
        chk("l1_rd1_cnt", n_rd1 - b_rd1, 0);
        chk("l1_rd_addr_seq", n_rd_bad, 0);
        chk("l1_wr_cnt", n_wr - b_wr, 256);
        chk("l1_wr_addr_seq", n_wr_bad, 0);
        chk("l1_filt_cnt", n_filt - b_filt, 1);
        chk("l1_rel0_cnt", n_rel0 - b_rel0, 1);
        chk("l1_done_cnt", n_done - b_done, 1);

        // Both banks ready over three lines: alternate 0,1,0
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        snap();
        s0 = served.size();
        bank_ready = 2'b11;
        run_line("a1", lat);
        tick();
        chk("gap_idle_busy", busy, 0);
        chk("gap_idle_filt", filt, 0);
        tick();
        chk("gap_start_filt", filt, 1);
        run_line("a2", lat);
        run_line("a3", lat);
        chk("a3_rel", rel, 1);
        bank_ready = 2'b00;
        repeat (2) tick();
        chk("alt_lines", served.size() - s0, 3);
        if (served.size() - s0 == 3) begin
            chk("alt_bank_a", served[s0], 0);
            chk("alt_bank_b", served[s0 + 1], 1);
            chk("alt_bank_c", served[s0 + 2], 0);
        end
        chk("alt_overlap", n_ovl - b_ovl, 0);
        chk("alt_rel0", n_rel0 - b_rel0, 2);
        chk("alt_rel1", n_rel1 - b_rel1, 1);
        chk("alt_rd1_cnt", n_rd1 - b_rd1, 256);
        chk("alt_err", err, 0);

        // No filter output: drain timeout sets err
        kill = 1'b1;
        snap();
        bank_ready = 2'b01;
        run_line("to", lat);
        chk("to_latency", lat, 289);
        chk("to_err_done", err, 1);
        chk("to_rel", rel, 1);
        bank_ready = 2'b00;
        repeat (3) tick();
        chk("to_idle_busy", busy, 0);
        chk("to_err_sticky", err, 1);
        chk("to_wr_cnt", n_wr - b_wr, 0);
        kill = 1'b0;

        // ctrl_en dropped mid-line: line completes, no relaunch
        snap();
        bank_ready = 2'b01; ctrl_en = 1'b1;
        wait_for("ce_start", 0, 0, 50, n);
        wait_for("ce_addr100", 2, 100, 200, n);
        ctrl_en = 1'b0;
        wait_for("ce_done", 1, 0, 400, lat);
        chk("ce_done_delay", lat, 166);
        repeat (20) tick();
        chk("ce_no_restart", n_filt - b_filt, 1);
        chk("ce_idle_busy", busy, 0);
        chk("ce_rd_cnt", n_rd0 - b_rd0, 256);
        chk("ce_wr_cnt", n_wr - b_wr, 256);
        chk("ce_done_cnt", n_done - b_done, 1);
        chk("ce_err_sticky", err, 1);

        // Reset mid-line abandons it
        ctrl_en = 1'b1;
        wait_for("mr_start", 0, 0, 50, n);
        wait_for("mr_addr50", 2, 50, 200, n);
        snap();
        rst = 1'b1;
        tick();
        chk("mr_rd0", rd0, 0);         chk("mr_addr", rd_addr, 0);
        chk("mr_wr_addr", wr_addr, 0); chk("mr_busy", busy, 0);
        chk("mr_err", err, 0);
        repeat (3) tick();
        chk("mr_rel_cnt", n_rel0 + n_rel1 - b_rel0 - b_rel1, 0);
        chk("mr_done_cnt", n_done - b_done, 0);
        rst = 1'b0; bank_ready = 2'b11;
        s0 = served.size();
        run_line("mr_line", lat);
        chk("mr_latency", lat, 267);
        bank_ready = 2'b00;
        repeat (2) tick();
        chk("mr_first_bank", (served.size() > s0) ? served[s0] : -1, 0);

        // Short line on the LINE_LEN=2 instance
        bank_ready2 = 2'b01; ctrl_en2 = 1'b1;
        wait_for("s2_start", 3, 0, 50, n);
        wait_for("s2_done", 4, 0, 100, lat);
        chk("s2_latency", lat, 13);
        chk("s2_rel", rel2, 1);
        bank_ready2 = 2'b00;
        repeat (3) tick();
        chk("s2_rd_cnt", n2_rd, 2);
        chk("s2_rd_addr_seq", n2_rd_bad, 0);
        chk("s2_wr_cnt", n2_wr, 2);
        chk("s2_wr_addr_seq", n2_wr_bad, 0);
        chk("s2_busy", busy2, 0);
        chk("s2_err", err2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
